// File: rtl/univ_shift_reg.sv
// Universal shift register: hold/load/shift/rotate/arithmetic-shift operations plus a
// self-timed WIDTH-cycle serial burst that shifts a loaded word out while shifting a new one in.
module univ_shift_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic             start,
   input  logic [WIDTH-1:0] datain,
   input  logic             sin,
   output logic [WIDTH-1:0] dataout,
   output logic             sout,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] XFER = 1'b1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [WIDTH-1:0] data_reg, data_next;
   logic [CW-1:0]    cnt_reg, cnt_next;
   logic [0:0]       state_reg, state_next;
   logic             busy_reg, busy_next;
   logic             done_reg, done_next;

   always_comb begin
      data_next  = data_reg;
      cnt_next   = cnt_reg;
      state_next = state_reg;
      busy_next  = busy_reg;
      done_next  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (mode == 3'b111) begin
               // Burst start ignores en; without start, mode 111 simply holds.
               if (start) begin
                  data_next  = datain;
                  cnt_next   = '0;
                  busy_next  = 1'b1;
                  state_next = XFER;
               end
            end else if (en) begin
               case (mode)
                  3'b001:  data_next = datain;
                  3'b010:  data_next = {data_reg[WIDTH-2:0], sin};
                  3'b011:  data_next = {sin, data_reg[WIDTH-1:1]};
                  3'b100:  data_next = {data_reg[WIDTH-2:0], data_reg[WIDTH-1]};
                  3'b101:  data_next = {data_reg[0], data_reg[WIDTH-1:1]};
                  3'b110:  data_next = {data_reg[WIDTH-1], data_reg[WIDTH-1:1]};
                  default: data_next = data_reg;
               endcase
            end
         end
         XFER: begin
            data_next = {sin, data_reg[WIDTH-1:1]};
            if (cnt_reg == LAST) begin
               cnt_next   = '0;
               busy_next  = 1'b0;
               done_next  = 1'b1;
               state_next = IDLE;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         default: begin
            state_next = IDLE;
            busy_next  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_reg  <= '0;
         cnt_reg   <= '0;
         state_reg <= IDLE;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         data_reg  <= data_next;
         cnt_reg   <= cnt_next;
         state_reg <= state_next;
         busy_reg  <= busy_next;
         done_reg  <= done_next;
      end
   end

   // Left-going operations expose the MSB; everything else, including the burst, exposes the LSB.
   assign sout    = (!busy_reg && (mode == 3'b010 || mode == 3'b100)) ? data_reg[WIDTH-1]
                                                                      : data_reg[0];
   assign dataout = data_reg;
   assign busy    = busy_reg;
   assign done    = done_reg;

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised universal shift register that generalises the 4-bit PIPO register. Supports hold, parallel load, logical shift left and right, rotate, arithmetic shift right, and a self-timed serial burst mode. Burst mode shifts a loaded word out while shifting a new word in over WIDTH cycles, with busy/done handshake. Used as the common storage/serialiser primitive for the serial links and datapath registers in the design.

Parameters:
WIDTH, 8, data register width in bits; legal range 2..32.

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
en  input  1  operation enable for modes 000-110; ignored while busy
mode  input  3  operation select (see Behaviour)
start  input  1  burst start strobe; honoured only when mode==3'b111 and idle
datain  input  WIDTH  parallel load data
sin  input  1  serial input bit
dataout  output  WIDTH  register contents (registered)
sout  output  1  serial output bit (combinational from dataout and mode)
busy  output  1  high while a burst is in progress (registered)
done  output  1  one-cycle pulse marking burst completion (registered)

Behaviour:
- Reset (reset==0, asynchronous, overrides everything): dataout=0, busy=0, done=0, bit counter=0, FSM=IDLE. Deassertion takes effect at the next rising edge.
- FSM states: IDLE, XFER. done is a registered pulse, not a state.
- In IDLE with en==1, per rising edge (1-cycle latency, dataout updates at the edge):
  - 000: hold.
  - 001: load; dataout<=datain.
  - 010: shift left; dataout<={dataout[W-2:0],sin}.
  - 011: shift right; dataout<={sin,dataout[W-1:1]}.
  - 100: rotate left; dataout<={dataout[W-2:0],dataout[W-1]}.
  - 101: rotate right; dataout<={dataout[0],dataout[W-1:1]}.
  - 110: arithmetic shift right; dataout<={dataout[W-1],dataout[W-1:1]}.
  - 111 without start: hold.
- In IDLE with en==0: hold for modes 000-110.
- Burst start: in IDLE, mode==111 and start==1 at edge E0 (en is don't-care):
  - dataout<=datain, busy<=1, counter<=0, FSM->XFER.
  - start outside mode 111, or while busy, is ignored.
- XFER: each edge E1..EW does dataout<={sin,dataout[W-1:1]} and counter++.
  - At EW (counter==WIDTH-1 before the edge): busy<=0, done<=1, FSM->IDLE.
  - done clears at the following edge unless a new burst completes there.
  - busy is high for exactly WIDTH cycles.
  - Final dataout holds the WIDTH sin bits; the first-sampled bit is at the LSB.
- While busy, the en, mode, start and datain inputs are ignored; the burst cannot be aborted except by reset.
- Back-to-back bursts: start may be asserted in the cycle done is high (FSM in IDLE). A new burst then begins at that edge and done clears.
- sout:
  - dataout[W-1] when mode is 010 or 100 and not busy.
  - dataout[0] otherwise, including throughout the burst.
  - In burst, bit i of the loaded word appears on sout during cycle i after E0.
- Reset mid-burst: immediate clear per reset rule; no done pulse is produced.
- Width rule: counter width is $clog2(WIDTH); no arithmetic overflow is possible.

Test Plan:
1. Reset and load: assert reset low mid-cycle -> dataout=0x00, busy=0, done=0 immediately. Release, then mode=001, en=1, datain=0xA5 -> dataout=0xA5 after one edge.
2. Shifts (dataout=0xA5, en=1):
   - mode=010, sin=1 -> 0x4B.
   - then mode=011, sin=0 -> 0x25.
   - then mode=110 with dataout=0x96 -> 0xCB.
   - mode=100 on 0x81 -> 0x03; mode=101 on 0x81 -> 0xC0.
   - en=0 for 3 edges -> value unchanged.
3. Loopback burst: sin tied to sout, mode=111, start=1, datain=0x3C -> busy high for exactly 8 cycles, sout sequence 0,0,1,1,1,1,0,0, then a single-cycle done. Final dataout=0x3C.
4. Capture burst: datain=0xFF, sin driven 1,0,1,1,0,0,0,1 on E1..E8 -> dataout=0x8D at done. While busy, toggling mode/en/start/datain has no effect.
5. Back-to-back: start held high in the done cycle -> second burst starts immediately. busy stays high 8 more cycles, done pulses once per burst.
6. Reset mid-burst: reset low at E4 of a burst -> dataout=0, busy=0, no done pulse. Next start begins a clean 8-cycle burst.
